// File: rtl/dcache_miss_unit.sv
// dcache_miss_unit: blocking D-cache miss sequencer (victim writeback, 4-beat refill, store merge)
module dcache_miss_unit (
  input  logic        clock,
  input  logic        reset,
  output logic        io_req_ready,
  input  logic        io_req_valid,
  input  logic [31:0] io_req_bits_addr,
  input  logic [7:0]  io_req_bits_chosenWay,
  input  logic        io_req_bits_isDirtyWay,
  input  logic [19:0] io_req_bits_dirtyTag,
  input  logic [31:0] io_req_bits_data_0,
  input  logic [31:0] io_req_bits_data_1,
  input  logic [31:0] io_req_bits_data_2,
  input  logic [31:0] io_req_bits_data_3,
  input  logic        io_req_bits_isStore,
  input  logic [31:0] io_req_bits_storeData,
  input  logic [3:0]  io_req_bits_storeMask,
  output logic        io_mem_aw_valid,
  input  logic        io_mem_aw_ready,
  output logic [31:0] io_mem_aw_addr,
  output logic        io_mem_w_valid,
  input  logic        io_mem_w_ready,
  output logic [31:0] io_mem_w_data,
  output logic        io_mem_w_last,
  input  logic        io_mem_b_valid,
  output logic        io_mem_ar_valid,
  input  logic        io_mem_ar_ready,
  output logic [31:0] io_mem_ar_addr,
  input  logic        io_mem_r_valid,
  input  logic [31:0] io_mem_r_data,
  output logic        io_refill_valid,
  output logic [31:0] io_refill_addr,
  output logic [7:0]  io_refill_chosenWay,
  output logic        io_refill_dirty,
  output logic [31:0] io_refill_data_0,
  output logic [31:0] io_refill_data_1,
  output logic [31:0] io_refill_data_2,
  output logic [31:0] io_refill_data_3
);
  localparam int LINE_WORDS = 4;
  localparam int TAG_W = 20;
  localparam logic [2:0] S_IDLE = 3'd0, S_WB_AW = 3'd1, S_WB_W = 3'd2, S_WB_B = 3'd3,
                         S_RD_AR = 3'd4, S_RD_R = 3'd5, S_REFILL = 3'd6;
  logic [2:0] state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [31:2] addr_q, addr_d;
  logic [7:0] way_q, way_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic store_q, store_d;
  logic [31:0] sdata_q, sdata_d;
  logic [3:0] smask_q, smask_d;
  logic [31:0] wb_q [LINE_WORDS];
  logic [31:0] wb_d [LINE_WORDS];
  logic [31:0] line_q [LINE_WORDS];
  logic [31:0] line_d [LINE_WORDS];
  logic [31:0] refill_data [LINE_WORDS];
  logic unused_addr_bits;
  assign unused_addr_bits = ^io_req_bits_addr[1:0];
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    addr_d = addr_q;
    way_d = way_q;
    tag_d = tag_q;
    store_d = store_q;
    sdata_d = sdata_q;
    smask_d = smask_q;
    wb_d = wb_q;
    line_d = line_q;
    case (state_q)
      S_IDLE: if (io_req_valid) begin
        addr_d = io_req_bits_addr[31:2];
        way_d = io_req_bits_chosenWay;
        tag_d = io_req_bits_dirtyTag;
        store_d = io_req_bits_isStore;
        sdata_d = io_req_bits_storeData;
        smask_d = io_req_bits_storeMask;
        wb_d = '{io_req_bits_data_0, io_req_bits_data_1, io_req_bits_data_2, io_req_bits_data_3};
        state_d = io_req_bits_isDirtyWay ? S_WB_AW : S_RD_AR;
      end
      S_WB_AW: if (io_mem_aw_ready) begin
        state_d = S_WB_W;
        beat_d = 2'd0;
      end
      S_WB_W: if (io_mem_w_ready) begin
        beat_d = beat_q + 2'd1;
        state_d = beat_q == 2'd3 ? S_WB_B : S_WB_W;
      end
      S_WB_B: state_d = io_mem_b_valid ? S_RD_AR : S_WB_B;
      S_RD_AR: if (io_mem_ar_ready) begin
        state_d = S_RD_R;
        beat_d = 2'd0;
      end
      // refill completes on the 4th beat; the bus provides no last flag
      S_RD_R: if (io_mem_r_valid) begin
        line_d[beat_q] = io_mem_r_data;
        beat_d = beat_q + 2'd1;
        state_d = beat_q == 2'd3 ? S_REFILL : S_RD_R;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q <= '0;
      addr_q <= '0;
      way_q <= '0;
      tag_q <= '0;
      store_q <= 1'b0;
      sdata_q <= '0;
      smask_q <= '0;
      wb_q <= '{default: '0};
      line_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      addr_q <= addr_d;
      way_q <= way_d;
      tag_q <= tag_d;
      store_q <= store_d;
      sdata_q <= sdata_d;
      smask_q <= smask_d;
      wb_q <= wb_d;
      line_q <= line_d;
    end
  end
  // store bytes overlay only the word the store addressed
  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++)
      for (int k = 0; k < 4; k++)
        refill_data[i][8*k +: 8] = (store_q && addr_q[3:2] == 2'(i) && smask_q[k]) ? sdata_q[8*k +: 8] : line_q[i][8*k +: 8];
  end
  assign io_req_ready = state_q == S_IDLE;
  assign io_mem_aw_valid = state_q == S_WB_AW;
  assign io_mem_aw_addr = {tag_q, addr_q[11:4], 4'h0};
  assign io_mem_w_valid = state_q == S_WB_W;
  assign io_mem_w_data = wb_q[beat_q];
  assign io_mem_w_last = io_mem_w_valid && beat_q == 2'd3;
  assign io_mem_ar_valid = state_q == S_RD_AR;
  assign io_mem_ar_addr = {addr_q[31:4], 4'h0};
  assign io_refill_valid = state_q == S_REFILL;
  assign io_refill_addr = {addr_q[31:4], 4'h0};
  assign io_refill_chosenWay = way_q;
  assign io_refill_dirty = store_q;
  assign io_refill_data_0 = refill_data[0];
  assign io_refill_data_1 = refill_data[1];
  assign io_refill_data_2 = refill_data[2];
  assign io_refill_data_3 = refill_data[3];
endmodule

// File: tb/tb_dcache_miss_unit.sv
// tb_dcache_miss_unit: directed-vector bench for the D-cache miss sequencer
module tb_dcache_miss_unit;
  logic clock = 1'b0, reset = 1'b0;
  logic io_req_ready, io_req_valid = 1'b0;
  logic [31:0] io_req_bits_addr = '0;
  logic [7:0] io_req_bits_chosenWay = '0;
  logic io_req_bits_isDirtyWay = 1'b0;
  logic [19:0] io_req_bits_dirtyTag = '0;
  logic [31:0] io_req_bits_data_0 = '0, io_req_bits_data_1 = '0, io_req_bits_data_2 = '0, io_req_bits_data_3 = '0;
  logic io_req_bits_isStore = 1'b0;
  logic [31:0] io_req_bits_storeData = '0;
  logic [3:0] io_req_bits_storeMask = '0;
  logic io_mem_aw_valid, io_mem_aw_ready = 1'b0;
  logic [31:0] io_mem_aw_addr;
  logic io_mem_w_valid, io_mem_w_ready = 1'b0, io_mem_w_last;
  logic [31:0] io_mem_w_data;
  logic io_mem_b_valid = 1'b0;
  logic io_mem_ar_valid, io_mem_ar_ready = 1'b0;
  logic [31:0] io_mem_ar_addr;
  logic io_mem_r_valid = 1'b0;
  logic [31:0] io_mem_r_data = '0;
  logic io_refill_valid, io_refill_dirty;
  logic [31:0] io_refill_addr, io_refill_data_0, io_refill_data_1, io_refill_data_2, io_refill_data_3;
  logic [7:0] io_refill_chosenWay;
  int vec = 0, err = 0;

  dcache_miss_unit dut (
    .clock(clock), .reset(reset),
    .io_req_ready(io_req_ready), .io_req_valid(io_req_valid),
    .io_req_bits_addr(io_req_bits_addr), .io_req_bits_chosenWay(io_req_bits_chosenWay),
    .io_req_bits_isDirtyWay(io_req_bits_isDirtyWay), .io_req_bits_dirtyTag(io_req_bits_dirtyTag),
    .io_req_bits_data_0(io_req_bits_data_0), .io_req_bits_data_1(io_req_bits_data_1),
    .io_req_bits_data_2(io_req_bits_data_2), .io_req_bits_data_3(io_req_bits_data_3),
    .io_req_bits_isStore(io_req_bits_isStore), .io_req_bits_storeData(io_req_bits_storeData),
    .io_req_bits_storeMask(io_req_bits_storeMask),
    .io_mem_aw_valid(io_mem_aw_valid), .io_mem_aw_ready(io_mem_aw_ready), .io_mem_aw_addr(io_mem_aw_addr),
    .io_mem_w_valid(io_mem_w_valid), .io_mem_w_ready(io_mem_w_ready), .io_mem_w_data(io_mem_w_data),
    .io_mem_w_last(io_mem_w_last), .io_mem_b_valid(io_mem_b_valid),
    .io_mem_ar_valid(io_mem_ar_valid), .io_mem_ar_ready(io_mem_ar_ready), .io_mem_ar_addr(io_mem_ar_addr),
    .io_mem_r_valid(io_mem_r_valid), .io_mem_r_data(io_mem_r_data),
    .io_refill_valid(io_refill_valid), .io_refill_addr(io_refill_addr),
    .io_refill_chosenWay(io_refill_chosenWay), .io_refill_dirty(io_refill_dirty),
    .io_refill_data_0(io_refill_data_0), .io_refill_data_1(io_refill_data_1),
    .io_refill_data_2(io_refill_data_2), .io_refill_data_3(io_refill_data_3)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [7:0] way, input logic dirty, input logic [19:0] tag,
                         input logic [31:0] base, input logic st, input logic [31:0] sd, input logic [3:0] sm);
    io_req_bits_addr = a;
    io_req_bits_chosenWay = way;
    io_req_bits_isDirtyWay = dirty;
    io_req_bits_dirtyTag = tag;
    io_req_bits_data_0 = base;
    io_req_bits_data_1 = base + 1;
    io_req_bits_data_2 = base + 2;
    io_req_bits_data_3 = base + 3;
    io_req_bits_isStore = st;
    io_req_bits_storeData = sd;
    io_req_bits_storeMask = sm;
    io_req_valid = 1'b1;
  endtask

  // zero-wait clean miss; leaves the unit in its refill cycle
  task automatic run_miss(input logic [31:0] a, input logic st, input logic [31:0] sd, input logic [3:0] sm,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] words [4];
    words = '{w0, w1, w2, w3};
    set_req(a, 8'h02, 1'b0, 20'h0, 32'h0, st, sd, sm);
    tick();
    io_req_valid = 1'b0;
    io_mem_ar_ready = 1'b1;
    tick();
    io_mem_ar_ready = 1'b0;
    io_mem_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_mem_r_data = words[i];
      tick();
    end
    io_mem_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    vec++; if (io_req_ready !== 1'b1) begin err++; $display("FAIL reset_req_ready got %b exp 1", io_req_ready); end
    vec++; if ({io_mem_aw_valid, io_mem_w_valid, io_mem_ar_valid, io_refill_valid} !== 4'b0) begin err++; $display("FAIL reset_valids got %b exp 0000", {io_mem_aw_valid, io_mem_w_valid, io_mem_ar_valid, io_refill_valid}); end
    vec++; if (io_refill_data_0 !== 32'h0) begin err++; $display("FAIL reset_refill_data got %h exp 00000000", io_refill_data_0); end
  endtask

  task automatic test_clean_load();
    logic [31:0] rd [4];
    rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    set_req(32'h8000_1234, 8'h04, 1'b0, 20'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    vec++; if (io_req_ready !== 1'b1) begin err++; $display("FAIL clean_req_ready got %b exp 1", io_req_ready); end
    tick();
    io_req_valid = 1'b0;
    vec++; if (io_mem_ar_valid !== 1'b1 || io_mem_ar_addr !== 32'h8000_1230) begin err++; $display("FAIL clean_ar got v=%b a=%h exp v=1 a=80001230", io_mem_ar_valid, io_mem_ar_addr); end
    vec++; if (io_req_ready !== 1'b0) begin err++; $display("FAIL clean_busy_ready got %b exp 0", io_req_ready); end
    io_mem_ar_ready = 1'b1;
    tick();
    io_mem_ar_ready = 1'b0;
    io_mem_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_mem_r_data = rd[i];
      vec++; if ({io_mem_aw_valid, io_mem_w_valid, io_refill_valid} !== 3'b0) begin err++; $display("FAIL clean_no_wb beat%0d got %b exp 000", i, {io_mem_aw_valid, io_mem_w_valid, io_refill_valid}); end
      tick();
    end
    io_mem_r_valid = 1'b0;
    vec++; if (io_refill_valid !== 1'b1) begin err++; $display("FAIL clean_refill_at_6 got %b exp 1", io_refill_valid); end
    vec++; if ({io_refill_data_0, io_refill_data_1, io_refill_data_2, io_refill_data_3} !== {32'h11, 32'h22, 32'h33, 32'h44}) begin err++; $display("FAIL clean_data got %h %h %h %h exp 11 22 33 44", io_refill_data_0, io_refill_data_1, io_refill_data_2, io_refill_data_3); end
    vec++; if (io_refill_dirty !== 1'b0 || io_refill_addr !== 32'h8000_1230 || io_refill_chosenWay !== 8'h04) begin err++; $display("FAIL clean_meta got d=%b a=%h w=%h exp d=0 a=80001230 w=04", io_refill_dirty, io_refill_addr, io_refill_chosenWay); end
    tick();
    vec++; if (io_refill_valid !== 1'b0 || io_req_ready !== 1'b1) begin err++; $display("FAIL clean_back_idle got rv=%b rr=%b exp rv=0 rr=1", io_refill_valid, io_req_ready); end
  endtask

  task automatic test_dirty_backpressure();
    set_req(32'h0000_0234, 8'h01, 1'b1, 20'hABCDE, 32'hA0, 1'b0, 32'h0, 4'h0);
    tick();
    io_req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vec++; if (io_mem_aw_valid !== 1'b1 || io_mem_aw_addr !== 32'hABCD_E230) begin err++; $display("FAIL dirty_aw_hold c%0d got v=%b a=%h exp v=1 a=abcde230", c, io_mem_aw_valid, io_mem_aw_addr); end
      vec++; if ({io_mem_w_valid, io_mem_ar_valid} !== 2'b0) begin err++; $display("FAIL dirty_no_w_before_aw c%0d got %b exp 00", c, {io_mem_w_valid, io_mem_ar_valid}); end
      tick();
    end
    io_mem_aw_ready = 1'b1;
    tick();
    io_mem_aw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        for (int c = 0; c < 3; c++) begin
          vec++; if (io_mem_w_valid !== 1'b1 || io_mem_w_data !== 32'hA1) begin err++; $display("FAIL dirty_w_hold c%0d got v=%b d=%h exp v=1 d=a1", c, io_mem_w_valid, io_mem_w_data); end
          tick();
        end
      end
      io_mem_w_ready = 1'b1;
      vec++; if (io_mem_w_valid !== 1'b1 || io_mem_w_data !== 32'hA0 + i || io_mem_w_last !== (i == 3)) begin err++; $display("FAIL dirty_w_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, io_mem_w_valid, io_mem_w_data, io_mem_w_last, 32'hA0 + i, i == 3); end
      tick();
      io_mem_w_ready = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      vec++; if ({io_mem_aw_valid, io_mem_w_valid, io_mem_ar_valid} !== 3'b0) begin err++; $display("FAIL dirty_wait_b c%0d got %b exp 000", c, {io_mem_aw_valid, io_mem_w_valid, io_mem_ar_valid}); end
      tick();
    end
    io_mem_b_valid = 1'b1;
    tick();
    io_mem_b_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vec++; if (io_mem_ar_valid !== 1'b1 || io_mem_ar_addr !== 32'h0000_0230) begin err++; $display("FAIL dirty_ar_hold c%0d got v=%b a=%h exp v=1 a=00000230", c, io_mem_ar_valid, io_mem_ar_addr); end
      tick();
    end
    io_mem_ar_ready = 1'b1;
    tick();
    io_mem_ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      io_mem_r_valid = 1'b0;
      io_mem_r_data = 32'hFFFF_FFFF;
      tick();
      vec++; if (io_refill_valid !== 1'b0) begin err++; $display("FAIL dirty_r_gap%0d refill got %b exp 0", i, io_refill_valid); end
      io_mem_r_valid = 1'b1;
      io_mem_r_data = 32'hB0 + i;
      tick();
    end
    io_mem_r_valid = 1'b0;
    vec++; if ({io_refill_valid, io_refill_dirty} !== 2'b10 || io_refill_chosenWay !== 8'h01) begin err++; $display("FAIL dirty_refill got v=%b d=%b w=%h exp v=1 d=0 w=01", io_refill_valid, io_refill_dirty, io_refill_chosenWay); end
    vec++; if ({io_refill_data_0, io_refill_data_1, io_refill_data_2, io_refill_data_3} !== {32'hB0, 32'hB1, 32'hB2, 32'hB3}) begin err++; $display("FAIL dirty_data got %h %h %h %h exp b0 b1 b2 b3", io_refill_data_0, io_refill_data_1, io_refill_data_2, io_refill_data_3); end
    tick();
  endtask

  task automatic test_store_merge();
    run_miss(32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 4'b0101, 32'h0, 32'h1, 32'h1234_5678, 32'h3);
    vec++; if (io_refill_data_2 !== 32'h12AD_56EF) begin err++; $display("FAIL store_merge_word2 got %h exp 12ad56ef", io_refill_data_2); end
    vec++; if ({io_refill_data_0, io_refill_data_1, io_refill_data_3} !== {32'h0, 32'h1, 32'h3}) begin err++; $display("FAIL store_other_words got %h %h %h exp 0 1 3", io_refill_data_0, io_refill_data_1, io_refill_data_3); end
    vec++; if (io_refill_dirty !== 1'b1 || io_refill_addr !== 32'h0000_1000) begin err++; $display("FAIL store_meta got d=%b a=%h exp d=1 a=00001000", io_refill_dirty, io_refill_addr); end
    tick();
    run_miss(32'h0000_100C, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h5, 32'h6, 32'h7, 32'h8);
    vec++; if (io_refill_data_3 !== 32'h8 || io_refill_dirty !== 1'b1) begin err++; $display("FAIL store_mask0 got d3=%h dirty=%b exp d3=8 dirty=1", io_refill_data_3, io_refill_dirty); end
    tick();
    run_miss(32'h0000_2000, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h9, 32'hA, 32'hB, 32'hC);
    vec++; if (io_refill_data_0 !== 32'hCAFE_F00D || io_refill_data_1 !== 32'hA) begin err++; $display("FAIL store_full_word0 got %h %h exp cafef00d 0000000a", io_refill_data_0, io_refill_data_1); end
    tick();
  endtask

  task automatic test_busy();
    set_req(32'h4000_0010, 8'h08, 1'b0, 20'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    tick();
    io_req_valid = 1'b0;
    io_mem_ar_ready = 1'b1;
    tick();
    io_mem_ar_ready = 1'b0;
    io_mem_r_valid = 1'b1;
    io_mem_r_data = 32'h1;
    tick();
    io_req_valid = 1'b1;
    io_req_bits_addr = 32'h5555_5550;
    io_req_bits_isDirtyWay = 1'b1;
    for (int i = 1; i < 4; i++) begin
      vec++; if (io_req_ready !== 1'b0) begin err++; $display("FAIL busy_ready beat%0d got %b exp 0", i, io_req_ready); end
      io_mem_r_data = 32'h1 + i;
      tick();
    end
    io_mem_r_valid = 1'b0;
    vec++; if (io_req_ready !== 1'b0 || io_refill_valid !== 1'b1) begin err++; $display("FAIL busy_refill got rr=%b rv=%b exp rr=0 rv=1", io_req_ready, io_refill_valid); end
    vec++; if (io_refill_addr !== 32'h4000_0010 || io_refill_data_3 !== 32'h4) begin err++; $display("FAIL busy_not_latched got a=%h d3=%h exp a=40000010 d3=4", io_refill_addr, io_refill_data_3); end
    tick();
    io_req_valid = 1'b0;
    vec++; if (io_req_ready !== 1'b1 || {io_mem_aw_valid, io_mem_ar_valid} !== 2'b0) begin err++; $display("FAIL busy_after got rr=%b aw/ar=%b exp rr=1 aw/ar=00", io_req_ready, {io_mem_aw_valid, io_mem_ar_valid}); end
  endtask

  task automatic test_reset_mid_wb();
    set_req(32'h0000_0450, 8'h10, 1'b1, 20'h12345, 32'hD0, 1'b0, 32'h0, 4'h0);
    tick();
    io_req_valid = 1'b0;
    io_mem_aw_ready = 1'b1;
    tick();
    io_mem_aw_ready = 1'b0;
    io_mem_w_ready = 1'b1;
    tick();
    vec++; if (io_mem_w_valid !== 1'b1 || io_mem_w_data !== 32'hD1) begin err++; $display("FAIL rst_pre_w got v=%b d=%h exp v=1 d=d1", io_mem_w_valid, io_mem_w_data); end
    io_mem_w_ready = 1'b0;
    reset = 1'b0;
    tick();
    vec++; if ({io_mem_aw_valid, io_mem_w_valid, io_mem_ar_valid, io_refill_valid} !== 4'b0) begin err++; $display("FAIL rst_mid_valids got %b exp 0000", {io_mem_aw_valid, io_mem_w_valid, io_mem_ar_valid, io_refill_valid}); end
    reset = 1'b1;
    vec++; if (io_req_ready !== 1'b1) begin err++; $display("FAIL rst_mid_ready got %b exp 1", io_req_ready); end
    run_miss(32'h0000_3000, 1'b0, 32'h0, 4'h0, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    vec++; if (io_refill_valid !== 1'b1 || io_refill_data_0 !== 32'hC0 || io_refill_data_3 !== 32'hC3) begin err++; $display("FAIL rst_restart got v=%b d0=%h d3=%h exp v=1 d0=c0 d3=c3", io_refill_valid, io_refill_data_0, io_refill_data_3); end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_dirty_backpressure();
    test_store_merge();
    test_busy();
    test_reset_mid_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
